// File: rtl/hazard_stall_unit.sv
// Hazard controller beside ID: load-use and mult/div stalls, taken-branch flush,
// and the mult/div busy window tracked by a two-state FSM with a down-counter.
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEXregRt,
    input  logic [4:0]  IFIDregRs,
    input  logic [4:0]  IFIDregRt,
    input  logic        IFID_UsesRt,
    input  logic        IFID_ReadsHiLo,
    input  logic        IFID_IsMD,
    input  logic        md_start,
    input  logic        branch_taken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);
    localparam logic [3:0] LP_LAT = 4'(MD_LATENCY);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    md_state_t   r_state;
    md_state_t   w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [15:0] r_stall_cycles;
    logic        w_lu;
    logic        w_mdh;
    logic        w_stall;

    assign w_lu = IDEX_MemRead && (IDEXregRt != 5'd0) &&
                  ((IDEXregRt == IFIDregRs) || (IFID_UsesRt && (IDEXregRt == IFIDregRt)));

    // A HI/LO consumer or a second mult/div waits until the last busy cycle.
    assign w_mdh = (IFID_ReadsHiLo || IFID_IsMD) &&
                   (((r_state == S_IDLE) && md_start) ||
                    ((r_state == S_BUSY) && (r_cnt > 4'd1)));

    assign w_stall = (w_lu || w_mdh) && !branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // md_start while busy is dropped: the next md instruction is held in ID.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (md_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = LP_LAT;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Gated by rst_n so a visible hazard cannot leak out during reset.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        if (rst_n) begin
            if (branch_taken) begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end else if (w_stall) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEX_Bubble = 1'b1;
            end
        end
    end

    assign md_busy = (r_state == S_BUSY);
    assign md_done = (r_state == S_BUSY) && (r_cnt == 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 16'd0;
        end else if (!PCWrite && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: cycle-indexed behavioural model compared every
// negedge, plus directed scenarios with literal expectations.
module tb_hazard_stall_unit;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IDEX_MemRead = 1'b0;
    logic [4:0]  IDEXregRt = 5'd0;
    logic [4:0]  IFIDregRs = 5'd0;
    logic [4:0]  IFIDregRt = 5'd0;
    logic        IFID_UsesRt = 1'b0;
    logic        IFID_ReadsHiLo = 1'b0;
    logic        IFID_IsMD = 1'b0;
    logic        md_start = 1'b0;
    logic        branch_taken = 1'b0;
    logic        PCWrite, IFIDWrite, IFID_Flush, IDEX_Bubble, md_busy, md_done;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    hazard_stall_unit #(.MD_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .IDEX_MemRead(IDEX_MemRead), .IDEXregRt(IDEXregRt),
        .IFIDregRs(IFIDregRs), .IFIDregRt(IFIDregRt), .IFID_UsesRt(IFID_UsesRt),
        .IFID_ReadsHiLo(IFID_ReadsHiLo), .IFID_IsMD(IFID_IsMD),
        .md_start(md_start), .branch_taken(branch_taken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .md_busy(md_busy), .md_done(md_done),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Model: m_cyc counts cycles since reset; an accepted mult/div started in
    // cycle m_t0 keeps the unit busy in cycles m_t0+1 .. m_t0+LAT.
    int m_cyc, m_t0, m_stall;
    logic m_busy, m_lu, m_mdh, e_stall;
    logic e_pc, e_ifid, e_flush, e_bubble, e_done;

    always_comb begin
        m_busy  = (m_t0 >= 0) && (m_cyc > m_t0) && (m_cyc <= m_t0 + LAT);
        m_lu    = IDEX_MemRead && IDEXregRt != 0 &&
                  (IDEXregRt == IFIDregRs || (IFID_UsesRt && IDEXregRt == IFIDregRt));
        m_mdh   = (IFID_ReadsHiLo || IFID_IsMD) &&
                  ((!m_busy && md_start) || (m_busy && m_cyc < m_t0 + LAT));
        e_stall = (m_lu || m_mdh) && !branch_taken;
        e_done  = m_busy && (m_cyc == m_t0 + LAT);
        e_pc    = 1'b1;
        e_ifid  = 1'b1;
        e_flush = 1'b0;
        e_bubble = 1'b0;
        if (rst_n) begin
            e_flush  = branch_taken;
            e_pc     = !e_stall;
            e_ifid   = !e_stall;
            e_bubble = branch_taken || e_stall;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   <= 0;
            m_t0    <= -1;
            m_stall <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!m_busy && md_start) m_t0 <= m_cyc;
            if (!e_pc && m_stall < 65535) m_stall <= m_stall + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("PCWrite", 32'(PCWrite), 32'(e_pc));
        chk("IFIDWrite", 32'(IFIDWrite), 32'(e_ifid));
        chk("IFID_Flush", 32'(IFID_Flush), 32'(e_flush));
        chk("IDEX_Bubble", 32'(IDEX_Bubble), 32'(e_bubble));
        chk("md_busy", 32'(md_busy), 32'(m_busy));
        chk("md_done", 32'(md_done), 32'(e_done));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IDEX_MemRead = 0; IDEXregRt = 0; IFIDregRs = 0; IFIDregRt = 0;
        IFID_UsesRt = 0; IFID_ReadsHiLo = 0; IFID_IsMD = 0;
        md_start = 0; branch_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        tick();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    initial begin
        // reset state, with a hazard visible on the inputs
        IDEX_MemRead = 1; IDEXregRt = 5; IFIDregRs = 5;
        at_sample();
        chk("rst_PCWrite", 32'(PCWrite), 32'd1);
        chk("rst_Bubble", 32'(IDEX_Bubble), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_count", 32'(stall_cycles), 32'd0);
        do_reset();

        // load-use: one stall cycle
        IDEX_MemRead = 1; IDEXregRt = 5; IFIDregRs = 5;
        at_sample();
        chk("lu_PCWrite", 32'(PCWrite), 32'd0);
        chk("lu_IFIDWrite", 32'(IFIDWrite), 32'd0);
        chk("lu_Bubble", 32'(IDEX_Bubble), 32'd1);
        tick();
        idle_inputs();
        at_sample();
        chk("lu_release", 32'(PCWrite), 32'd1);
        chk("lu_count", 32'(stall_cycles), 32'd1);

        // no false stalls
        tick();
        IDEX_MemRead = 1; IDEXregRt = 0; IFIDregRs = 0;
        at_sample();
        chk("r0_nostall", 32'(PCWrite), 32'd1);
        tick();
        IDEXregRt = 7; IFIDregRs = 3; IFIDregRt = 7; IFID_UsesRt = 0;
        at_sample();
        chk("rt_unused_nostall", 32'(PCWrite), 32'd1);
        tick();
        IFID_UsesRt = 1;
        at_sample();
        chk("rt_used_stall", 32'(PCWrite), 32'd0);
        tick();

        // mult then mfhi
        do_reset();
        md_start = 1; IFID_ReadsHiLo = 1;
        for (int c = 0; c <= LAT + 1; c++) begin
            at_sample();
            chk($sformatf("md_stall_c%0d", c), 32'(PCWrite), (c < LAT) ? 32'd0 : 32'd1);
            chk($sformatf("md_busy_c%0d", c), 32'(md_busy), (c >= 1 && c <= LAT) ? 32'd1 : 32'd0);
            chk($sformatf("md_done_c%0d", c), 32'(md_done), (c == LAT) ? 32'd1 : 32'd0);
            if (c == LAT) chk("md_count", 32'(stall_cycles), 32'd4);
            tick();
            md_start = 0;
            if (c == LAT) IFID_ReadsHiLo = 0;
        end

        // branch beats load-use
        do_reset();
        IDEX_MemRead = 1; IDEXregRt = 9; IFIDregRs = 9; branch_taken = 1;
        at_sample();
        chk("br_Flush", 32'(IFID_Flush), 32'd1);
        chk("br_Bubble", 32'(IDEX_Bubble), 32'd1);
        chk("br_PCWrite", 32'(PCWrite), 32'd1);
        chk("br_IFIDWrite", 32'(IFIDWrite), 32'd1);
        tick();
        idle_inputs();
        at_sample();
        chk("br_count", 32'(stall_cycles), 32'd0);
        tick();

        // reset in the middle of BUSY
        do_reset();
        md_start = 1; IFID_ReadsHiLo = 1;
        tick();
        md_start = 0;
        tick();
        at_sample();
        chk("mid_busy_before", 32'(md_busy), 32'd1);
        rst_n = 0;
        #1;
        chk("mid_busy_now", 32'(md_busy), 32'd0);
        chk("mid_done_now", 32'(md_done), 32'd0);
        chk("mid_count", 32'(stall_cycles), 32'd0);
        tick();
        tick();
        rst_n = 1;
        IFID_ReadsHiLo = 0;
        md_start = 1;
        for (int c = 0; c <= LAT + 1; c++) begin
            at_sample();
            chk($sformatf("re_busy_c%0d", c), 32'(md_busy), (c >= 1 && c <= LAT) ? 32'd1 : 32'd0);
            tick();
            md_start = 0;
        end

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            IDEX_MemRead   = ($urandom_range(0, 2) == 0);
            IDEXregRt      = 5'($urandom_range(0, 3));
            IFIDregRs      = 5'($urandom_range(0, 3));
            IFIDregRt      = 5'($urandom_range(0, 3));
            IFID_UsesRt    = 1'($urandom);
            IFID_ReadsHiLo = ($urandom_range(0, 3) == 0);
            IFID_IsMD      = ($urandom_range(0, 5) == 0);
            md_start       = ($urandom_range(0, 4) == 0);
            branch_taken   = ($urandom_range(0, 6) == 0);
            rst_n          = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1;

        // saturation under a permanent load-use hazard
        do_reset();
        IDEX_MemRead = 1; IDEXregRt = 5; IFIDregRs = 5;
        for (int i = 0; i < 70000; i++) tick();
        at_sample();
        chk("sat_count", 32'(stall_cycles), 32'h0000FFFF);
        chk("sat_PCWrite", 32'(PCWrite), 32'd0);
        tick();
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
